alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the main datapath and a branch/compare helper unit.
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Sequences one operation at a time through the ALU.
- Returns the registered result, tagged with the requester ID, over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU datapath.
- OPW, 3, ALU opcode width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a1  in  WIDTH  requester 0 operand A1.
- req0_a2  in  WIDTH  requester 0 operand A2.
- req0_op  in  OPW  requester 0 ALU opcode.
- req1_valid / req1_ready / req1_a1 / req1_a2 / req1_op  same widths and meanings, for requester 1.
- alu_a1  out  WIDTH  to ALU A1.
- alu_a2  out  WIDTH  to ALU A2.
- alu_op  out  OPW  to ALU ALU_op.
- alu_ans  in  WIDTH  from ALU ans.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_id  out  1  requester that issued the result.
- resp_data  out  WIDTH  result.
- resp_err  out  1  opcode was illegal (101/110/111).

Behaviour:
- Reset values (async, all outputs and state):
  - state=IDLE; alu_a1=0, alu_a2=0, alu_op=000.
  - resp_valid=0, resp_id=0, resp_data=0, resp_err=0.
  - last_grant=1, so requester 0 wins the first contention.
- IDLE:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - Assert the granted reqX_ready combinationally in this same cycle; never both readies.
  - On the clock edge: latch the granted a1/a2/op into the alu_a1/alu_a2/alu_op registers, latch resp_id, set last_grant=granted ID, go EXEC.
  - No valid: stay IDLE; alu_* hold their last values.
- EXEC (exactly one cycle):
  - ALU evaluates the held operands combinationally.
  - Legal op (000 add, 001 sub, 010 or, 011 eq, 100 invert low bits): resp_data<=alu_ans, resp_err<=0.
  - Illegal op: resp_data<=0, resp_err<=1; alu_ans ignored.
  - Go RESP.
- RESP:
  - resp_valid=1; resp_data/resp_id/resp_err stable while resp_ready=0.
  - On resp_ready=1: clear resp_valid at the edge, go IDLE.
  - No new request accepted while in EXEC or RESP; both readies are 0.
- Latency and throughput:
  - Accept edge at cycle N → resp_valid high from cycle N+2.
  - Minimum spacing between accepts: 3 cycles, with resp_ready tied high.
- Requesters must hold valid and payload until ready; the arbiter never drops a pending request.
- A valid deasserted before grant is permitted; no grant is made for it.
- Reset mid-operation: any in-flight operation is discarded, no response is issued, and last_grant returns to 1.
- Widths: results are passed through unmodified; no truncation/extension inside the block.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, 16 bits each, plus err_cnt, 8 bits.
  - grant_cntX increments on each accept from requester X.
  - err_cnt increments on each EXEC with an illegal op.
  - All counters wrap modulo 2^n, reset to 0 on rst_n, and are updated in the same edge as the event.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset, then req0_valid only (a1=5, a2=3, op=000):
  - req0_ready=1 for one cycle.
  - resp_valid two cycles later with resp_id=0, resp_data=8, resp_err=0.
- Both valid continuously with resp_ready=1, req0 op=001 (10,4), req1 op=010 (0xF0,0x0F):
  - Grants alternate 0,1,0,1.
  - Responses alternate 6 (id0) and 0xFF (id1).
- Backpressure: resp_ready=0 for 5 cycles after resp_valid, op=011 (7,7):
  - resp_data=1 held stable.
  - No readies asserted.
  - Completes the cycle after resp_ready=1.
- Illegal op=110 from req1:
  - resp_err=1, resp_data=0, resp_id=1.
  - With ALU_ARB_STATS_EN: err_cnt=1.
- op=100, a1=0x0000_00FF, a2=4 → resp_data=0x0000_00F0.
- rst_n pulsed low during EXEC:
  - resp_valid never rises for that op.
  - After release with both valid, requester 0 is granted first.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters; one op in flight at a time.
// Optional statistics counters are enabled with `define ALU_ARB_STATS_EN.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a1,
  input  logic [WIDTH-1:0] req0_a2,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a1,
  input  logic [WIDTH-1:0] req1_a2,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_a1,
  output logic [WIDTH-1:0] alu_a2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_ans,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
  output logic [7:0]       err_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] OP_LAST_LEGAL = OPW'(4);

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   grant_id;
  logic   accept;
  logic   op_illegal;

  assign op_illegal = (alu_op > OP_LAST_LEGAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    grant_id   = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        // On contention the requester that did not win last time takes priority.
        if (req0_valid && req1_valid) grant_id = ~last_grant_q;
        else                          grant_id = req1_valid;
        accept     = req0_valid | req1_valid;
        req0_ready = accept & ~grant_id;
        req1_ready = accept & grant_id;
        if (accept) state_d = EXEC;
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a1       <= '0;
      alu_a2       <= '0;
      alu_op       <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_data    <= '0;
      resp_err     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      if (accept) begin
        alu_a1       <= grant_id ? req1_a1 : req0_a1;
        alu_a2       <= grant_id ? req1_a2 : req0_a2;
        alu_op       <= grant_id ? req1_op : req0_op;
        resp_id      <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        resp_valid <= 1'b1;
        resp_data  <= op_illegal ? '0 : alu_ans;
        resp_err   <= op_illegal;
      end
      if (state_q == RESP && resp_ready) resp_valid <= 1'b0;
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      err_cnt    <= '0;
    end else begin
      if (accept && !grant_id) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (accept &&  grant_id) grant_cnt1 <= grant_cnt1 + 16'd1;
      if (state_q == EXEC && op_illegal) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural ALU model; define ALU_ARB_STATS_EN to check the counters.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a1 = '0, req0_a2 = '0, req1_a1 = '0, req1_a2 = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] alu_a1, alu_a2, alu_ans;
  logic [2:0]  alu_op;
  logic        resp_valid, resp_id, resp_err;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
  logic [7:0]  err_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a1(req0_a1), .req0_a2(req0_a2), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a1(req1_a1), .req1_a2(req1_a2), .req1_op(req1_op),
    .alu_a1(alu_a1), .alu_a2(alu_a2), .alu_op(alu_op), .alu_ans(alu_ans),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err)
`ifdef ALU_ARB_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
  );

  // Behavioural ALU; illegal opcodes return junk that the arbiter must discard.
  always_comb begin
    case (alu_op)
      3'b000:  alu_ans = alu_a1 + alu_a2;
      3'b001:  alu_ans = alu_a1 - alu_a2;
      3'b010:  alu_ans = alu_a1 | alu_a2;
      3'b011:  alu_ans = {31'd0, alu_a1 == alu_a2};
      3'b100:  alu_ans = alu_a1 ^ ((alu_a2 >= 32) ? 32'hFFFF_FFFF : ((32'd1 << alu_a2) - 32'd1));
      default: alu_ans = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct packed {
    logic        r;
    logic [31:0] a1;
    logic [31:0] a2;
    logic [2:0]  op;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic r, input logic v, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [2:0] op);
    if (r) begin req1_valid = v; req1_a1 = a1; req1_a2 = a2; req1_op = op; end
    else   begin req0_valid = v; req0_a1 = a1; req0_a2 = a2; req0_op = op; end
  endtask

  function automatic logic rdy(input logic r);
    return r ? req1_ready : req0_ready;
  endfunction

  task automatic wait_ready(input logic r, input string tag);
    int unsigned waited = 0;
    while (!rdy(r) && waited < 20) begin tick(); waited++; end
    chk({tag, " ready"}, {31'd0, rdy(r)}, 32'd1);
    chk({tag, " other_ready"}, {31'd0, rdy(~r)}, 32'd0);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    set_req(v.r, 1'b1, v.a1, v.a2, v.op);
    #1;
    wait_ready(v.r, tag);
    tick();
    set_req(v.r, 1'b0, '0, '0, '0);
    #1;
    chk({tag, " exec_readies"}, {30'd0, req1_ready, req0_ready}, 32'd0);
    chk({tag, " exec_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    tick();
    chk({tag, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
    chk({tag, " resp_id"}, {31'd0, resp_id}, {31'd0, v.r});
    chk({tag, " resp_data"}, resp_data, v.exp_data);
    chk({tag, " resp_err"}, {31'd0, resp_err}, {31'd0, v.exp_err});
    tick();
    chk({tag, " resp_cleared"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int unsigned waited;
    int exp_errs;
    vecs[0]  = '{1'b0, 32'd5,          32'd3,    3'b000, 32'd8,          1'b0};
    vecs[1]  = '{1'b1, 32'd10,         32'd4,    3'b001, 32'd6,          1'b0};
    vecs[2]  = '{1'b0, 32'h0000_00F0,  32'h0F,   3'b010, 32'h0000_00FF,  1'b0};
    vecs[3]  = '{1'b1, 32'd7,          32'd7,    3'b011, 32'd1,          1'b0};
    vecs[4]  = '{1'b0, 32'd7,          32'd8,    3'b011, 32'd0,          1'b0};
    vecs[5]  = '{1'b1, 32'h0000_00FF,  32'd4,    3'b100, 32'h0000_00F0,  1'b0};
    vecs[6]  = '{1'b1, 32'd9,          32'd2,    3'b110, 32'd0,          1'b1};
    vecs[7]  = '{1'b0, 32'd1,          32'd2,    3'b101, 32'd0,          1'b1};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,    3'b000, 32'd0,          1'b0};
    vecs[9]  = '{1'b1, 32'd0,          32'd1,    3'b001, 32'hFFFF_FFFF,  1'b0};
    vecs[10] = '{1'b0, 32'h1234_5678,  32'd0,    3'b111, 32'd0,          1'b1};

    // Reset state
    #2;
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_id", {31'd0, resp_id}, 32'd0);
    chk("rst resp_data", resp_data, 32'd0);
    chk("rst resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst alu_a1", alu_a1, 32'd0);
    chk("rst alu_a2", alu_a2, 32'd0);
    chk("rst alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst readies", {30'd0, req1_ready, req0_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Directed vector table
    exp_errs = 0;
    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      if (vecs[i].exp_err) exp_errs++;
`ifdef ALU_ARB_STATS_EN
      chk($sformatf("vec%0d err_cnt", i), {24'd0, err_cnt}, exp_errs);
`endif
    end

    // Continuous contention alternates grants starting with requester 0
    do_reset();
    set_req(1'b0, 1'b1, 32'd10, 32'd4, 3'b001);
    set_req(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b010);
    #1;
    for (int k = 0; k < 4; k++) begin
      logic exp_id;
      exp_id = k[0];
      waited = 0;
      while (!(req0_ready || req1_ready) && waited < 20) begin tick(); waited++; end
      if (k > 0) chk($sformatf("alt%0d spacing", k), waited, 32'd0);
      chk($sformatf("alt%0d req0_ready", k), {31'd0, req0_ready}, {31'd0, ~exp_id});
      chk($sformatf("alt%0d req1_ready", k), {31'd0, req1_ready}, {31'd0, exp_id});
      tick();
      tick();
      chk($sformatf("alt%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("alt%0d resp_id", k), {31'd0, resp_id}, {31'd0, exp_id});
      chk($sformatf("alt%0d resp_data", k), resp_data, exp_id ? 32'h0000_00FF : 32'd6);
      tick();
    end
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
`ifdef ALU_ARB_STATS_EN
    chk("alt grant_cnt0", {16'd0, grant_cnt0}, 32'd2);
    chk("alt grant_cnt1", {16'd0, grant_cnt1}, 32'd2);
`endif
    tick();

    // Backpressure: result held, nothing accepted while waiting
    resp_ready = 1'b0;
    set_req(1'b0, 1'b1, 32'd7, 32'd7, 3'b011);
    #1;
    wait_ready(1'b0, "bp");
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    tick();
    set_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b000);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d resp_valid", c), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d resp_data", c), resp_data, 32'd1);
      chk($sformatf("bp%0d resp_id", c), {31'd0, resp_id}, 32'd0);
      chk($sformatf("bp%0d readies", c), {30'd0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("bp release resp_valid", {31'd0, resp_valid}, 32'd1);
    tick();
    chk("bp done resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp idle req1_ready", {31'd0, req1_ready}, 32'd1);
    // Withdrawn request must not be granted
    set_req(1'b1, 1'b0, '0, '0, '0);
    #1;
    chk("withdraw req1_ready", {31'd0, req1_ready}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("withdraw%0d resp_valid", c), {31'd0, resp_valid}, 32'd0);
    end

    // Reset during EXEC discards the op and restores requester-0 priority
    set_req(1'b0, 1'b1, 32'd2, 32'd2, 3'b000);
    #1;
    wait_ready(1'b0, "rx");
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rx alu_a1", alu_a1, 32'd0);
    chk("rx resp_valid", {31'd0, resp_valid}, 32'd0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("rx%0d resp_valid", c), {31'd0, resp_valid}, 32'd0);
    end
    set_req(1'b0, 1'b1, 32'd20, 32'd22, 3'b000);
    set_req(1'b1, 1'b1, 32'd1, 32'd1, 3'b000);
    #1;
    chk("rx req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("rx req1_ready", {31'd0, req1_ready}, 32'd0);
    tick();
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    tick();
    chk("rx resp_valid", {31'd0, resp_valid}, 32'd1);
    chk("rx resp_data", resp_data, 32'd42);
    chk("rx resp_id", {31'd0, resp_id}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
